// File: rtl/wire_alu_seq.sv
// wire_alu_seq: sequential ADD/SUB/MUL/DIV engine behind host wire-ins/wire-outs.
// MUL and DIV run 32 iterative steps; results publish atomically on FINISH exit.
module wire_alu_seq #(
  parameter int CNT_W = 8
) (
  input  logic        okClk,
  input  logic        reset_n,
  input  logic [31:0] cmd_word,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic [31:0] status
);
  typedef enum logic [1:0] {IDLE, ITER, FINISH} state_t;
  state_t state_q, state_d;
  logic go, start, accept, busy, div_ge;
  logic go_q, go_d, armed_q, armed_d;
  logic [31:0] a_q, a_d, b_q, b_d, acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [31:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d, div_sub;
  logic [1:0] op_q, op_d;
  logic [5:0] it_q, it_d;
  logic done_q, done_d, div0_q, div0_d, ovr_q, ovr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [32:0] mul_sum, div_sh, add_sum, sub_dif;
  logic [7:0] cnt8;
  logic unused_cmd;
  assign unused_cmd = ^cmd_word[31:3];
  assign go = cmd_word[0];
  // armed_q blocks a start until go has been seen low after reset
  assign start = go & ~go_q & armed_q;
  assign accept = start & (state_q == IDLE);
  always_ff @(posedge okClk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? (cmd_word[2] ? ITER : FINISH) : IDLE;
      ITER:    state_d = (it_q == 6'd31) ? FINISH : ITER;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_q} : 33'd0);
    div_sh  = {acc_hi_q, acc_lo_q[31]};
    div_ge  = div_sh >= {1'b0, b_q};
    div_sub = div_sh[31:0] - b_q;
    add_sum = {1'b0, a_q} + {1'b0, b_q};
    sub_dif = {1'b0, a_q} - {1'b0, b_q};
    go_d = go;
    armed_d = armed_q | ~go;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    it_d = it_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    done_d = done_q;
    div0_d = div0_q;
    ovr_d = ovr_q | (start & ~accept);
    cnt_d = cnt_q;
    if (accept) begin
      a_d = op_a;
      b_d = op_b;
      op_d = cmd_word[2:1];
      acc_hi_d = '0;
      acc_lo_d = (cmd_word[2:1] == 2'b10) ? op_b : op_a;
      it_d = '0;
      done_d = 1'b0;
      div0_d = 1'b0;
      ovr_d = 1'b0;
    end
    if (state_q == ITER) begin
      it_d = it_q + 6'd1;
      acc_hi_d = op_q[0] ? (div_ge ? div_sub : div_sh[31:0]) : mul_sum[32:1];
      acc_lo_d = op_q[0] ? {acc_lo_q[30:0], div_ge} : {mul_sum[0], acc_lo_q[31:1]};
    end
    if (state_q == FINISH) begin
      res_lo_d = op_q[1] ? acc_lo_q : (op_q[0] ? sub_dif[31:0] : add_sum[31:0]);
      res_hi_d = op_q[1] ? acc_hi_q : {31'b0, op_q[0] ? sub_dif[32] : add_sum[32]};
      done_d = 1'b1;
      div0_d = (op_q == 2'b11) && (b_q == '0);
      cnt_d = cnt_q + CNT_W'(1);
    end
  end
  always_ff @(posedge okClk or negedge reset_n)
    if (!reset_n) begin
      go_q <= 1'b0;
      armed_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      it_q <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      done_q <= 1'b0;
      div0_q <= 1'b0;
      ovr_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      go_q <= go_d;
      armed_q <= armed_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      it_q <= it_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      done_q <= done_d;
      div0_q <= div0_d;
      ovr_q <= ovr_d;
      cnt_q <= cnt_d;
    end
  always_comb begin
    busy = state_q != IDLE;
    cnt8 = 8'(cnt_q);
    status = {14'b0, op_q, cnt8, 4'b0, ovr_q, div0_q, done_q, busy};
    result_lo = res_lo_q;
    result_hi = res_hi_q;
  end
endmodule
